// File: rtl/axis_chk_pkg.sv
// rtl/axis_chk_pkg.sv - shared FSM states, event record and LFSR constants for the AXIS sample checker
package axis_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } chk_state_e;

    // Per-beat outcome, captured at the accepting edge and applied to the stats one cycle later
    typedef struct packed {
        logic err;
        logic data_err;
        logic last_err;
        logic good;
    } chk_evt_t;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/axis_chk_lfsr.sv
// rtl/axis_chk_lfsr.sv - free-running 16-bit Fibonacci LFSR used to throttle the checker's tready
module axis_chk_lfsr
    import axis_chk_pkg::*;
(
    input  logic Clk,
    input  logic ResetN,
    output logic o_bit
);

    logic [15:0] r_lfsr;

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign o_bit = r_lfsr[0];

endmodule

// File: rtl/axis_sample_checker.sv
// rtl/axis_sample_checker.sv - AXI-Stream frame/sequence checker with stats; AXIS_CHK_THROTTLE_EN adds LFSR tready throttling
module axis_sample_checker
    import axis_chk_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int FRAME_LEN = 7,
    parameter int CNT_W     = 16
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              En,
    input  logic              ClearStats,
    input  logic              S_AXIS_tvalid,
    output logic              S_AXIS_tready,
    input  logic              S_AXIS_tlast,
    input  logic [DATA_W-1:0] S_AXIS_tdata,
    output logic [CNT_W-1:0]  FrameCount,
    output logic [CNT_W-1:0]  ErrCount,
    output logic              DataErr,
    output logic              LastErr
);

    localparam logic [DATA_W-1:0] LAST_IDX = DATA_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    chk_state_e        r_state;
    logic              r_tready;
    logic [DATA_W-1:0] r_index;
    logic              r_frame_err;
    chk_evt_t          r_evt;
    logic [CNT_W-1:0]  r_frame_cnt;
    logic [CNT_W-1:0]  r_err_cnt;
    logic              r_data_err;
    logic              r_last_err;

    logic              w_gate;
    logic              w_accept;
    logic              w_data_mis;
    logic              w_early;
    logic              w_missing;
    logic              w_beat_err;
    logic              w_good;
    chk_evt_t          w_evt;

`ifdef AXIS_CHK_THROTTLE_EN
    logic w_lfsr_bit;

    axis_chk_lfsr u_lfsr (
        .Clk    (Clk),
        .ResetN (ResetN),
        .o_bit  (w_lfsr_bit)
    );

    assign w_gate = w_lfsr_bit;
`else
    assign w_gate = 1'b1;
`endif

    assign w_accept   = S_AXIS_tvalid & r_tready;
    assign w_data_mis = (S_AXIS_tdata != r_index);
    assign w_early    = S_AXIS_tlast & (r_index < LAST_IDX);
    assign w_missing  = ~S_AXIS_tlast & (r_index == LAST_IDX);
    assign w_beat_err = w_data_mis | w_early | w_missing;
    // A tlast past LAST_IDX (after a missing tlast) is never good: r_frame_err is already set
    assign w_good     = S_AXIS_tlast & (r_index == LAST_IDX) & ~r_frame_err & ~w_data_mis;

    always_comb begin
        w_evt          = '0;
        w_evt.err      = w_accept & w_beat_err;
        w_evt.data_err = w_accept & w_data_mis;
        w_evt.last_err = w_accept & (w_early | w_missing);
        w_evt.good     = w_accept & w_good;
    end

    // tready follows the state with one cycle of lag
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            r_state  <= ST_IDLE;
            r_tready <= 1'b0;
        end else begin
            r_tready <= (r_state != ST_IDLE) & w_gate;
            case (r_state)
                ST_IDLE: begin
                    if (En) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!En) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if ((r_index == '0) || (w_accept && S_AXIS_tlast)) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Expected index never resyncs to the incoming data
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            r_index     <= '0;
            r_frame_err <= 1'b0;
        end else if (w_accept) begin
            if (S_AXIS_tlast) begin
                r_index     <= '0;
                r_frame_err <= 1'b0;
            end else begin
                r_index     <= r_index + DATA_W'(1);
                r_frame_err <= r_frame_err | w_beat_err;
            end
        end
    end

    // ClearStats also drops an event still in flight so nothing lands after the clear
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            r_evt       <= '0;
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
            r_data_err  <= 1'b0;
            r_last_err  <= 1'b0;
        end else if (ClearStats) begin
            r_evt       <= '0;
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
            r_data_err  <= 1'b0;
            r_last_err  <= 1'b0;
        end else begin
            r_evt <= w_evt;
            if (r_evt.good && (r_frame_cnt != CNT_MAX)) begin
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
            if (r_evt.err && (r_err_cnt != CNT_MAX)) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
            if (r_evt.data_err) begin
                r_data_err <= 1'b1;
            end
            if (r_evt.last_err) begin
                r_last_err <= 1'b1;
            end
        end
    end

    assign S_AXIS_tready = r_tready;
    assign FrameCount    = r_frame_cnt;
    assign ErrCount      = r_err_cnt;
    assign DataErr       = r_data_err;
    assign LastErr       = r_last_err;

endmodule

// File: tb/tb_axis_sample_checker.sv
// tb/tb_axis_sample_checker.sv - randomized and directed self-checking bench for axis_sample_checker
module tb_axis_sample_checker;

    localparam int FL = 7;

    logic        Clk = 1'b0;
    logic        ResetN = 1'b0;
    logic        En = 1'b0;
    logic        ClearStats = 1'b0;
    logic        S_AXIS_tvalid = 1'b0;
    logic        S_AXIS_tlast = 1'b0;
    logic [7:0]  S_AXIS_tdata = 8'h00;

    logic        S_AXIS_tready;
    logic [15:0] FrameCount;
    logic [15:0] ErrCount;
    logic        DataErr;
    logic        LastErr;
    logic        sat_tready;
    logic [1:0]  sat_frame_count;
    logic [1:0]  sat_err_count;
    logic        sat_data_err;
    logic        sat_last_err;

    int n_checks = 0;
    int n_fail = 0;

    int m_pos = 0;
    bit m_frame_bad = 0;
    int m_frames = 0;
    int m_errs = 0;
    bit m_derr = 0;
    bit m_lerr = 0;

    always #5 Clk = ~Clk;

    axis_sample_checker #(.DATA_W(8), .FRAME_LEN(FL), .CNT_W(16)) dut (
        .Clk           (Clk),
        .ResetN        (ResetN),
        .En            (En),
        .ClearStats    (ClearStats),
        .S_AXIS_tvalid (S_AXIS_tvalid),
        .S_AXIS_tready (S_AXIS_tready),
        .S_AXIS_tlast  (S_AXIS_tlast),
        .S_AXIS_tdata  (S_AXIS_tdata),
        .FrameCount    (FrameCount),
        .ErrCount      (ErrCount),
        .DataErr       (DataErr),
        .LastErr       (LastErr)
    );

    axis_sample_checker #(.DATA_W(8), .FRAME_LEN(FL), .CNT_W(2)) dut_sat (
        .Clk           (Clk),
        .ResetN        (ResetN),
        .En            (En),
        .ClearStats    (ClearStats),
        .S_AXIS_tvalid (S_AXIS_tvalid),
        .S_AXIS_tready (sat_tready),
        .S_AXIS_tlast  (S_AXIS_tlast),
        .S_AXIS_tdata  (S_AXIS_tdata),
        .FrameCount    (sat_frame_count),
        .ErrCount      (sat_err_count),
        .DataErr       (sat_data_err),
        .LastErr       (sat_last_err)
    );

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: a beat's expected value is its position since the last accepted tlast
    function automatic void model_accept(input logic [7:0] d, input bit l);
        int  idx;
        bit  de, early, miss;
        idx   = m_pos % 256;
        de    = (int'(d) != idx);
        early = l && (idx < FL - 1);
        miss  = !l && (idx == FL - 1);
        if (de || early || miss) begin
            m_errs++;
            m_frame_bad = 1;
        end
        if (de) m_derr = 1;
        if (early || miss) m_lerr = 1;
        if (l) begin
            if ((idx == FL - 1) && !m_frame_bad) m_frames++;
            m_pos = 0;
            m_frame_bad = 0;
        end else begin
            m_pos++;
        end
    endfunction

    function automatic void model_clear();
        m_frames = 0;
        m_errs = 0;
        m_derr = 0;
        m_lerr = 0;
    endfunction

    function automatic int sat2(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic send_beat(input logic [7:0] d, input bit l, input bit clr);
        int w = 0;
        S_AXIS_tvalid = 1'b1;
        S_AXIS_tdata = d;
        S_AXIS_tlast = l;
        ClearStats = clr;
        while (!S_AXIS_tready && w < 64) begin
            @(negedge Clk);
            w++;
        end
        if (w >= 64) check_val("tready_wait", S_AXIS_tready, 1);
        else model_accept(d, l);
        if (clr) model_clear();
        @(negedge Clk);
        S_AXIS_tvalid = 1'b0;
        S_AXIS_tlast = 1'b0;
        ClearStats = 1'b0;
    endtask

    task automatic send_seq(input int n, input int err_pos, input logic [7:0] err_val, input bit gaps);
        for (int i = 0; i < n; i++) begin
            send_beat((i == err_pos) ? err_val : 8'(i), (i == n - 1), 1'b0);
            if (gaps && $urandom_range(0, 3) == 0) @(negedge Clk);
        end
    endtask

    task automatic settle();
        S_AXIS_tvalid = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic clear_stats();
        ClearStats = 1'b1;
        @(negedge Clk);
        ClearStats = 1'b0;
        model_clear();
        @(negedge Clk);
    endtask

    task automatic compare_stats(input string tag);
        check_val({tag, "_frames"}, FrameCount, m_frames);
        check_val({tag, "_errs"}, ErrCount, m_errs);
        check_val({tag, "_dataerr"}, DataErr, m_derr);
        check_val({tag, "_lasterr"}, LastErr, m_lerr);
        check_val({tag, "_sat_frames"}, sat_frame_count, sat2(m_frames));
        check_val({tag, "_sat_errs"}, sat_err_count, sat2(m_errs));
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_tready"}, S_AXIS_tready, 0);
        check_val({tag, "_frames"}, FrameCount, 0);
        check_val({tag, "_errs"}, ErrCount, 0);
        check_val({tag, "_dataerr"}, DataErr, 0);
        check_val({tag, "_lasterr"}, LastErr, 0);
        check_val({tag, "_sat_tready"}, sat_tready, 0);
        check_val({tag, "_sat_errs"}, sat_err_count, 0);
    endtask

    initial begin
        int t, n, ep;
        logic [7:0] ev;

        repeat (3) @(negedge Clk);
        check_all_zero("reset");
        ResetN = 1'b1;
        En = 1'b1;
        repeat (3) @(negedge Clk);
        check_val("run_tready", S_AXIS_tready, 1);

        // Clean stream
        for (int f = 0; f < 3; f++) send_seq(FL, -1, 8'h00, 1'b0);
        settle();
        compare_stats("clean");
        check_val("clean_fc_const", FrameCount, 3);
        check_val("clean_ec_const", ErrCount, 0);

        // Data error, next frame clean
        clear_stats();
        send_seq(FL, 3, 8'd9, 1'b0);
        send_seq(FL, -1, 8'h00, 1'b0);
        settle();
        compare_stats("dataerr");
        check_val("dataerr_fc_const", FrameCount, 1);
        check_val("dataerr_ec_const", ErrCount, 1);

        // Early tlast on beat 4
        clear_stats();
        send_seq(5, -1, 8'h00, 1'b0);
        send_seq(FL, -1, 8'h00, 1'b0);
        settle();
        compare_stats("early");
        check_val("early_le_const", LastErr, 1);

        // Missing tlast, frame runs to index 9
        clear_stats();
        send_seq(10, -1, 8'h00, 1'b0);
        send_seq(FL, -1, 8'h00, 1'b0);
        settle();
        compare_stats("missing");
        check_val("missing_ec_const", ErrCount, 1);
        check_val("missing_fc_const", FrameCount, 1);

        // Saturation of the 2-bit instance
        clear_stats();
        for (int f = 0; f < 5; f++) send_seq(FL, 2, 8'hFF, 1'b0);
        settle();
        compare_stats("sat");
        check_val("sat_ec_const", sat_err_count, 3);
        check_val("sat_big_ec_const", ErrCount, 5);

        // ClearStats on the same edge that accepts an errored beat
        send_beat(8'h55, 1'b0, 1'b1);
        for (int i = 1; i < FL; i++) send_beat(8'(i), (i == FL - 1), 1'b0);
        settle();
        compare_stats("clr_err");
        check_val("clr_err_ec_const", ErrCount, 0);

        // Drain: En drops at beat 2, tready must hold until tlast
        send_beat(8'd0, 1'b0, 1'b0);
        send_beat(8'd1, 1'b0, 1'b0);
        En = 1'b0;
        send_beat(8'd2, 1'b0, 1'b0);
        for (int i = 3; i < FL; i++) begin
            check_val($sformatf("drain_tready_b%0d", i), S_AXIS_tready, 1);
            send_beat(8'(i), (i == FL - 1), 1'b0);
        end
        @(negedge Clk);
        check_val("drain_tready_low", S_AXIS_tready, 0);
        S_AXIS_tvalid = 1'b1;
        S_AXIS_tdata = 8'h00;
        repeat (4) @(negedge Clk);
        check_val("idle_tready_low", S_AXIS_tready, 0);
        settle();
        compare_stats("drain");

        // Reset mid-frame with nonzero stats
        En = 1'b1;
        repeat (3) @(negedge Clk);
        send_beat(8'd0, 1'b0, 1'b0);
        send_beat(8'd1, 1'b0, 1'b0);
        send_beat(8'h77, 1'b0, 1'b0);
        settle();
        compare_stats("prereset");
        ResetN = 1'b0;
        @(negedge Clk);
        check_all_zero("midreset");
        ResetN = 1'b1;
        m_pos = 0;
        m_frame_bad = 0;
        model_clear();
        repeat (3) @(negedge Clk);
        send_seq(FL, -1, 8'h00, 1'b0);
        settle();
        compare_stats("postreset");
        check_val("postreset_fc_const", FrameCount, 1);

        // Randomized frames against the reference model
        for (int f = 0; f < 40; f++) begin
            t = $urandom_range(0, 3);
            ep = -1;
            case (t)
                0: n = FL;
                1: begin n = FL; ep = $urandom_range(0, FL - 1); end
                2: n = $urandom_range(1, FL - 1);
                default: n = $urandom_range(FL + 1, FL + 5);
            endcase
            if (t != 1 && $urandom_range(0, 4) == 0) ep = $urandom_range(0, n - 1);
            ev = (ep >= 0) ? (8'(ep) ^ 8'($urandom_range(1, 255))) : 8'h00;
            send_seq(n, ep, ev, 1'b1);
            settle();
            compare_stats($sformatf("rand%0d", f));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
